// File: rtl/codec_cfg_seq.sv
// Audio-codec configuration sequencer: waits out codec power-up, then streams a
// ROM table of register writes to the I2C master with bounded retry on NACK.
module codec_cfg_seq #(
    parameter int          NUM_REGS      = 10,
    parameter logic [31:0] POWERUP_DELAY = 32'd500_000,
    parameter int          MAX_RETRIES   = 3,
    parameter logic [6:0]  DEV_ADDR      = 7'h1A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        i2c_req,
    output logic [6:0]  i2c_dev_addr,
    output logic [15:0] i2c_data,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  cur_index
);
    localparam int RW = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
    localparam logic [3:0]    LAST_IDX    = 4'(NUM_REGS - 1);
    localparam logic [31:0]   PWR_LOAD    = (POWERUP_DELAY == 32'd0) ? 32'd0 : POWERUP_DELAY - 32'd1;
    localparam logic          PWR_SKIP    = (POWERUP_DELAY == 32'd0);

    typedef enum logic [2:0] {
        WAIT_PWR,
        FETCH,
        LOAD,
        ISSUE,
        WAIT_ACK,
        DONE,
        ERROR
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [31:0]     pwr_cnt;
    logic            pwr_done;
    logic [3:0]      index;
    logic [RW-1:0]   retries;
    logic            last_entry;
    logic            out_of_retries;

    assign last_entry     = (index == LAST_IDX);
    assign out_of_retries = ((retries + RW'(1)) == RETRY_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset) state <= WAIT_PWR;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            WAIT_PWR: if (pwr_done) next_state = FETCH;
            FETCH:    next_state = LOAD;
            LOAD:     next_state = ISSUE;
            ISSUE:    if (i2c_busy) next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (i2c_done) begin
                    if (!i2c_nack) next_state = last_entry ? DONE : FETCH;
                    else           next_state = out_of_retries ? ERROR : ISSUE;
                end
            end
            DONE, ERROR: if (start) next_state = FETCH;
            default:  next_state = WAIT_PWR;
        endcase
    end

    always_comb begin
        i2c_req   = 1'b0;
        cfg_done  = 1'b0;
        cfg_error = 1'b0;
        unique case (state)
            ISSUE:   i2c_req   = 1'b1;
            DONE:    cfg_done  = 1'b1;
            ERROR:   cfg_error = 1'b1;
            default: ;
        endcase
    end

    // The count runs PWR_LOAD..0 and then spends one terminal cycle latching
    // pwr_done, so the first request lands POWERUP_DELAY+2 cycles after release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwr_cnt  <= PWR_LOAD;
            pwr_done <= PWR_SKIP;
        end else if (state == WAIT_PWR && !pwr_done) begin
            if (pwr_cnt == 32'd0) pwr_done <= 1'b1;
            else                  pwr_cnt  <= pwr_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            index    <= '0;
            retries  <= '0;
            i2c_data <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    i2c_data <= rom_data;
                    retries  <= '0;
                end
                WAIT_ACK: begin
                    if (i2c_done) begin
                        if (!i2c_nack) index   <= index + 4'd1;
                        else           retries <= retries + RW'(1);
                    end
                end
                DONE, ERROR: if (start) index <= '0;
                default: ;
            endcase
        end
    end

    assign rom_addr     = index;
    assign cur_index    = index;
    assign i2c_dev_addr = DEV_ADDR;

endmodule

// File: doc/codec_cfg_seq.md
# codec_cfg_seq

Audio-codec configuration sequencer. After reset it waits a power-up delay, then walks a register-write table in an external synchronous ROM. Each entry goes to the I2C master as one transaction through a req/busy/done handshake, with bounded retry on NACK. It sits beside the I2S output path in the APU: it owns the I2C master and reports completion, error and the current table index for the seven-segment debug display.

## Interface
Parameters:
- NUM_REGS, 10: number of table entries (1..16).
- POWERUP_DELAY, 32'd500_000: cycles to wait after reset before the first write (10 ms at 50 MHz).
- MAX_RETRIES, 3: total attempts per entry before declaring an error (>=1).
- DEV_ADDR, 7'h1A: codec 7-bit I2C address.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on clk.
- start  in  1  one-cycle pulse: rerun the table; honoured only in DONE or ERROR.
- rom_addr  out  4  table index presented to the ROM.
- rom_data  in  16  {reg_addr[6:0], value[8:0]}; valid one cycle after rom_addr.
- i2c_req  out  1  transaction request to the I2C master.
- i2c_dev_addr  out  7  constant DEV_ADDR.
- i2c_data  out  16  latched table word for the current transaction.
- i2c_busy  in  1  master has accepted the request and is running.
- i2c_done  in  1  one-cycle pulse at the end of a transaction.
- i2c_nack  in  1  qualifies i2c_done; high means the slave NACKed.
- cfg_done  out  1  all entries written successfully; level.
- cfg_error  out  1  an entry exhausted its retries; level.
- cur_index  out  4  index of the entry in progress or last attempted.

## Operation
- States: WAIT_PWR, FETCH, LOAD, ISSUE, WAIT_ACK, DONE, ERROR.
- WAIT_PWR: a 32-bit counter loads POWERUP_DELAY-1 and counts to 0, then moves to FETCH. With POWERUP_DELAY=0 it moves to FETCH after 1 cycle.
- FETCH: rom_addr = index. Next state LOAD.
- LOAD: captures rom_data into i2c_data and clears the retry counter on the first attempt only. Next state ISSUE.
- ISSUE: i2c_req=1. Holds until i2c_busy is sampled 1; the next state is WAIT_ACK, and i2c_req is 0 from that cycle.
- WAIT_ACK: waits for i2c_done.
  - i2c_done with i2c_nack=0: index+1; if the new index equals NUM_REGS go to DONE, else go to FETCH.
  - i2c_done with i2c_nack=1: retries+1; if retries equals MAX_RETRIES go to ERROR, else return to ISSUE with i2c_data unchanged.
- DONE: cfg_done=1. A start pulse clears cfg_done, sets index=0 and goes to FETCH; the power-up delay is not repeated.
- ERROR: cfg_error=1 and cur_index holds the failing entry. start behaves as in DONE and also clears cfg_error.
- start in any other state is ignored.
- Retry counter is 2 bits wide minimum, sized for MAX_RETRIES. Index is 4 bits and never exceeds NUM_REGS.

## Timing
- Reset (reset=0 on an edge): state=WAIT_PWR, delay counter reloaded, index=0, retries=0.
- Reset values of all outputs: i2c_req=0, i2c_data=0, rom_addr=0, cfg_done=0, cfg_error=0, cur_index=0, i2c_dev_addr=DEV_ADDR.
- Reset asserted mid-transaction drops i2c_req on that same edge. A later i2c_done is ignored because the sequencer is not in WAIT_ACK.
- With the first edge of reset=1 as cycle 0, i2c_req first rises in cycle POWERUP_DELAY+2.
- Between a successful i2c_done and the next i2c_req there are exactly 2 idle cycles (FETCH, LOAD).
- After a NACK, i2c_req re-rises in the cycle after i2c_done.
- cfg_done or cfg_error rises the cycle after the final i2c_done.
- i2c_done outside WAIT_ACK is ignored. i2c_busy outside ISSUE is ignored.
- i2c_req never stays high in the cycle after i2c_busy is sampled.

## Test plan
- Nominal run: NUM_REGS=3, POWERUP_DELAY=4, ROM {16'h1E00,16'h0C10,16'h1201}; master asserts busy 1 cycle after req and pulses done 10 cycles later with nack=0 -> first req at cycle 6; i2c_data sequence 1E00, 0C10, 1201; cfg_done=1; cur_index=3.
- Single NACK on entry 1 -> entry 1 is issued twice with identical i2c_data; cfg_done=1; cfg_error=0.
- Persistent NACK on entry 2 with MAX_RETRIES=3 -> exactly 3 requests at index 2, then cfg_error=1, cur_index=2 and no further req.
- Slow master holds busy=0 for 20 cycles -> i2c_req stays high for all 20 cycles and drops the cycle after busy=1.
- start pulsed during WAIT_ACK -> no effect. start pulsed in DONE -> cfg_done falls next cycle and first req follows 3 cycles after the start pulse, with no delay wait.
- reset=0 for 1 cycle during WAIT_ACK of entry 1 -> i2c_req and all outputs return to reset values; the sequence restarts at index 0 after POWERUP_DELAY cycles.
